// File: rtl/fir_coeff_sched.sv
// Coefficient scheduler for a transposed-form FIR: owns the active bank, stages reloads
// in a shadow bank, and drains the filter with zeros before swapping banks atomically.
module fir_coeff_sched #(
    parameter int NUMTAPS = 32,
    parameter int DATA_W  = 12,
    parameter int COEFF_W = 12,
    parameter int FIR_LAT = 2
) (
    input  logic                        Clk,
    input  logic                        Hlt,
    input  logic                        Cfg_Valid,
    output logic                        Cfg_Ready,
    input  logic [$clog2(NUMTAPS)-1:0]  Cfg_Addr,
    input  logic [COEFF_W-1:0]          Cfg_Data,
    input  logic                        Cfg_Commit,
    output logic                        Cmt_Err,
    input  logic                        Samp_Valid,
    output logic                        Samp_Ready,
    input  logic [DATA_W-1:0]           Samp_Data,
    output logic [DATA_W-1:0]           Fir_Din,
    output logic [NUMTAPS*COEFF_W-1:0]  Fir_Coeff,
    output logic                        Out_Valid,
    output logic                        Busy,
    output logic                        Underrun
);

    localparam int FILL_MAX = NUMTAPS + FIR_LAT;
    localparam int CW       = $clog2(FILL_MAX + 1);

    // First half of the symmetric default response; the second half mirrors it.
    localparam int DEF_HALF [16] = '{-3, 0, 1, 4, 10, 19, 31, 46,
                                     64, 83, 103, 123, 141, 156, 167, 173};

    typedef enum logic {RUN, FLUSH} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        fill_cnt, fill_nxt;
    logic [CW-1:0]        flush_cnt;
    logic [NUMTAPS-1:0]   mask, mask_wr;
    logic [COEFF_W-1:0]   shadow [NUMTAPS];
    logic [COEFF_W-1:0]   active [NUMTAPS];
    logic                 cfg_wr;
    logic                 flush_last;
    logic                 commit_ok;
    logic                 cmt_err_nxt;

    function automatic logic [COEFF_W-1:0] def_tap(input int unsigned k);
        int unsigned m;
        m = (k < NUMTAPS / 2) ? k : NUMTAPS - 1 - k;
        return (m < 16) ? COEFF_W'(DEF_HALF[m[3:0]]) : '0;
    endfunction

    assign Samp_Ready = (state == RUN);
    assign Cfg_Ready  = (state == RUN);
    assign Busy       = (state == FLUSH);

    always_comb begin
        Fir_Coeff = '0;
        for (int unsigned k = 0; k < NUMTAPS; k++) begin
            Fir_Coeff[k*COEFF_W +: COEFF_W] = active[k];
        end
    end

    // Commit sees the mask with this cycle's shadow write already folded in.
    always_comb begin
        cfg_wr  = Cfg_Valid & Cfg_Ready;
        mask_wr = mask;
        if (cfg_wr) begin
            mask_wr[Cfg_Addr] = 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        commit_ok   = 1'b0;
        cmt_err_nxt = 1'b0;
        flush_last  = (state == FLUSH) && (flush_cnt == CW'(FILL_MAX - 1));
        fill_nxt    = fill_cnt;
        case (state)
            RUN: begin
                if (fill_cnt != CW'(FILL_MAX)) begin
                    fill_nxt = fill_cnt + CW'(1);
                end
                if (Cfg_Commit) begin
                    if (&mask_wr) begin
                        state_nxt = FLUSH;
                        commit_ok = 1'b1;
                    end else begin
                        cmt_err_nxt = 1'b1;
                    end
                end
            end
            FLUSH: begin
                cmt_err_nxt = Cfg_Commit;
                if (flush_last) begin
                    state_nxt = RUN;
                    fill_nxt  = '0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Hlt) begin
            state     <= RUN;
            fill_cnt  <= '0;
            flush_cnt <= '0;
            mask      <= '0;
            Fir_Din   <= '0;
            Out_Valid <= 1'b0;
            Cmt_Err   <= 1'b0;
            Underrun  <= 1'b0;
            for (int unsigned k = 0; k < NUMTAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= def_tap(k);
            end
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_nxt;
            Cmt_Err   <= cmt_err_nxt;
            Out_Valid <= (state_nxt == RUN) && (fill_nxt == CW'(FILL_MAX));
            mask      <= mask_wr;
            if (cfg_wr) begin
                shadow[Cfg_Addr] <= Cfg_Data;
            end
            if (state == RUN) begin
                Fir_Din <= Samp_Valid ? Samp_Data : '0;
                if (!Samp_Valid) begin
                    Underrun <= 1'b1;
                end
                if (commit_ok) begin
                    flush_cnt <= '0;
                end
            end else begin
                Fir_Din   <= '0;
                flush_cnt <= flush_cnt + CW'(1);
                // Filter is fully drained of old-bank products: swap the whole bank in one edge.
                if (flush_last) begin
                    mask     <= '0;
                    Underrun <= 1'b0;
                    for (int unsigned k = 0; k < NUMTAPS; k++) begin
                        active[k] <= shadow[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_sched.sv
// Self-checking bench for fir_coeff_sched: randomized traffic against a bank/flush
// reference model that tracks taps, written flags and cycles since the last swap.
module tb_fir_coeff_sched;

    localparam int NT   = 32;
    localparam int DW   = 12;
    localparam int CWD  = 12;
    localparam int LAT  = 2;
    localparam int FILL = NT + LAT;

    logic            Clk = 1'b0;
    logic            Hlt, Cfg_Valid, Cfg_Ready, Cfg_Commit, Cmt_Err;
    logic            Samp_Valid, Samp_Ready, Out_Valid, Busy, Underrun;
    logic [4:0]      Cfg_Addr;
    logic [CWD-1:0]  Cfg_Data;
    logic [DW-1:0]   Samp_Data, Fir_Din;
    logic [NT*CWD-1:0] Fir_Coeff;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    fir_coeff_sched #(.NUMTAPS(NT), .DATA_W(DW), .COEFF_W(CWD), .FIR_LAT(LAT)) dut (
        .Clk(Clk), .Hlt(Hlt),
        .Cfg_Valid(Cfg_Valid), .Cfg_Ready(Cfg_Ready), .Cfg_Addr(Cfg_Addr), .Cfg_Data(Cfg_Data),
        .Cfg_Commit(Cfg_Commit), .Cmt_Err(Cmt_Err),
        .Samp_Valid(Samp_Valid), .Samp_Ready(Samp_Ready), .Samp_Data(Samp_Data),
        .Fir_Din(Fir_Din), .Fir_Coeff(Fir_Coeff), .Out_Valid(Out_Valid),
        .Busy(Busy), .Underrun(Underrun)
    );

    // ---------------- reference model ----------------
    int             def_tab [16] = '{-3, 0, 1, 4, 10, 19, 31, 46,
                                     64, 83, 103, 123, 141, 156, 167, 173};
    logic [CWD-1:0] m_active [NT];
    logic [CWD-1:0] m_shadow [NT];
    bit             m_written [NT];
    bit             m_flushing, m_under, m_err;
    int             m_flush_left, m_runs;
    logic [DW-1:0]  m_din;

    function automatic logic [CWD-1:0] def_coeff(input int k);
        return CWD'(def_tab[(k < NT/2) ? k : NT - 1 - k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NT; k++) begin
            m_active[k]  = def_coeff(k);
            m_shadow[k]  = '0;
            m_written[k] = 1'b0;
        end
        m_flushing = 1'b0; m_flush_left = 0; m_runs = 0;
        m_under = 1'b0; m_err = 1'b0; m_din = '0;
    endtask

    function automatic logic [DW+5:0] exp_ctrl();
        return {m_flushing, !m_flushing, !m_flushing, (!m_flushing && m_runs >= FILL),
                m_err, m_under, m_din};
    endfunction

    function automatic logic [NT*CWD-1:0] exp_coeff();
        logic [NT*CWD-1:0] v;
        v = '0;
        for (int k = 0; k < NT; k++) v[k*CWD +: CWD] = m_active[k];
        return v;
    endfunction

    // One clock edge; the model consumes the same inputs the DUT sampled.
    task automatic tick();
        bit all;
        @(posedge Clk);
        if (Hlt) begin
            model_reset();
        end else if (!m_flushing) begin
            m_din = Samp_Valid ? Samp_Data : '0;
            if (!Samp_Valid) m_under = 1'b1;
            if (m_runs < 1000) m_runs++;
            if (Cfg_Valid) begin
                m_shadow[Cfg_Addr]  = Cfg_Data;
                m_written[Cfg_Addr] = 1'b1;
            end
            m_err = 1'b0;
            if (Cfg_Commit) begin
                all = 1'b1;
                for (int k = 0; k < NT; k++) all &= m_written[k];
                if (all) begin
                    m_flushing   = 1'b1;
                    m_flush_left = FILL;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else begin
            m_din = '0;
            m_err = Cfg_Commit;
            m_flush_left--;
            if (m_flush_left == 0) begin
                for (int k = 0; k < NT; k++) begin
                    m_active[k]  = m_shadow[k];
                    m_written[k] = 1'b0;
                end
                m_under = 1'b0; m_runs = 0; m_flushing = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive(input bit hlt, input bit cv, input int ca, input logic [CWD-1:0] cd,
                         input bit cc, input bit sv, input logic [DW-1:0] sd);
        Hlt = hlt; Cfg_Valid = cv; Cfg_Addr = 5'(ca); Cfg_Data = cd;
        Cfg_Commit = cc; Samp_Valid = sv; Samp_Data = sd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1, 0, 0, '0, 0, 1, '0);
        repeat (3) tick();
        drive(0, 0, 0, '0, 0, 1, DW'($urandom));
        checks++;
        if (Fir_Coeff !== exp_coeff()) begin
            errors++; $display("FAIL reset_coeff act=%h exp=%h", Fir_Coeff, exp_coeff());
        end
        checks++;
        if (Fir_Coeff[11:0] !== 12'hFFD || Fir_Coeff[15*CWD +: CWD] !== 12'd173 ||
            Fir_Coeff[31*CWD +: CWD] !== 12'hFFD) begin
            errors++; $display("FAIL reset_taps act0=%h act15=%h act31=%h exp0=ffd exp15=0ad exp31=ffd",
                               Fir_Coeff[11:0], Fir_Coeff[15*CWD +: CWD], Fir_Coeff[31*CWD +: CWD]);
        end
        checks++;
        if ({Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din} !== exp_ctrl()) begin
            errors++; $display("FAIL reset_ctrl act=%h exp=%h",
                {Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din}, exp_ctrl());
        end
        for (int j = 1; j <= 40; j++) begin
            drive(0, 0, 0, '0, 0, 1, DW'($urandom));
            tick();
            checks++;
            if ({Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din} !== exp_ctrl()) begin
                errors++; $display("FAIL fill_ctrl cyc=%0d act=%h exp=%h", j,
                    {Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din}, exp_ctrl());
            end
            checks++;
            if (Out_Valid !== (j >= 34)) begin
                errors++; $display("FAIL out_valid_rise run_cycle=%0d act=%b exp=%b", j + 1, Out_Valid, j >= 34);
            end
        end
    endtask

    task automatic test_commit_full();
        int busy_cycles;
        for (int a = 0; a < NT; a++) begin
            drive(0, 1, a, (a == 0) ? 12'd2047 : 12'd0, 0, 1, DW'($urandom));
            tick();
        end
        drive(0, 0, 0, '0, 1, 1, DW'($urandom));
        tick();
        checks++;
        if ({Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din} !== exp_ctrl()) begin
            errors++; $display("FAIL commit_enter act=%h exp=%h",
                {Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din}, exp_ctrl());
        end
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (Busy === 1'b1) busy_cycles++;
            drive(0, $urandom_range(0, 1), $urandom_range(0, NT - 1), CWD'($urandom),
                  (i == 5), (Busy === 1'b1) ? 1'($urandom) : 1'b1, DW'($urandom));
            tick();
            checks++;
            if ({Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din} !== exp_ctrl()) begin
                errors++; $display("FAIL flush_ctrl i=%0d act=%h exp=%h", i,
                    {Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din}, exp_ctrl());
            end
            checks++;
            if (Fir_Coeff !== exp_coeff()) begin
                errors++; $display("FAIL flush_coeff i=%0d act=%h exp=%h", i, Fir_Coeff, exp_coeff());
            end
        end
        checks++;
        if (busy_cycles !== FILL) begin
            errors++; $display("FAIL flush_length act=%0d exp=%0d", busy_cycles, FILL);
        end
        checks++;
        if (Fir_Coeff[11:0] !== 12'd2047 || Fir_Coeff[CWD +: CWD] !== 12'd0) begin
            errors++; $display("FAIL swap_taps act0=%h act1=%h exp0=7ff exp1=000",
                               Fir_Coeff[11:0], Fir_Coeff[CWD +: CWD]);
        end
    endtask

    task automatic test_incomplete();
        for (int a = 0; a < NT; a++) begin
            if (a == 7) continue;
            drive(0, 1, a, CWD'($urandom), 0, 1, DW'($urandom));
            tick();
        end
        drive(0, 0, 0, '0, 1, 1, DW'($urandom));
        tick();
        checks++;
        if (Cmt_Err !== 1'b1 || Busy !== 1'b0) begin
            errors++; $display("FAIL incomplete_err act_err=%b act_busy=%b exp_err=1 exp_busy=0", Cmt_Err, Busy);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din} !== exp_ctrl()) begin
                errors++; $display("FAIL incomplete_ctrl i=%0d act=%h exp=%h", i,
                    {Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din}, exp_ctrl());
            end
            checks++;
            if (Fir_Coeff !== exp_coeff()) begin
                errors++; $display("FAIL incomplete_coeff i=%0d act=%h exp=%h", i, Fir_Coeff, exp_coeff());
            end
            drive(0, 0, 0, '0, 0, 1, DW'($urandom));
            tick();
        end
    endtask

    task automatic test_same_cycle_commit();
        drive(1, 0, 0, '0, 0, 1, '0);
        tick();
        for (int a = 0; a < NT - 1; a++) begin
            drive(0, 1, a, CWD'($urandom), 0, 1, DW'($urandom));
            tick();
        end
        drive(0, 0, 0, '0, 1, 1, DW'($urandom));
        tick();
        checks++;
        if ({Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din} !== exp_ctrl()) begin
            errors++; $display("FAIL missing31_ctrl act=%h exp=%h",
                {Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din}, exp_ctrl());
        end
        drive(0, 1, NT - 1, CWD'($urandom), 1, 1, DW'($urandom));
        tick();
        checks++;
        if (Busy !== 1'b1 || Cmt_Err !== 1'b0) begin
            errors++; $display("FAIL samecycle_commit act_busy=%b act_err=%b exp_busy=1 exp_err=0", Busy, Cmt_Err);
        end
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, '0, 0, 1, DW'($urandom));
            tick();
            checks++;
            if ({Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din} !== exp_ctrl() ||
                Fir_Coeff !== exp_coeff()) begin
                errors++; $display("FAIL samecycle_flush i=%0d act=%h exp=%h coeff_act=%h coeff_exp=%h", i,
                    {Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din}, exp_ctrl(),
                    Fir_Coeff, exp_coeff());
            end
        end
    endtask

    task automatic test_underrun();
        for (int a = 0; a < NT; a++) begin
            drive(0, 1, a, CWD'($urandom), 0, 1, DW'($urandom));
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, '0, 0, (i != 5), DW'($urandom));
            tick();
            checks++;
            if ({Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din} !== exp_ctrl()) begin
                errors++; $display("FAIL underrun_ctrl i=%0d act=%h exp=%h", i,
                    {Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din}, exp_ctrl());
            end
            checks++;
            if (Underrun !== (i >= 5) || (i == 5 && Fir_Din !== '0)) begin
                errors++; $display("FAIL underrun_sticky i=%0d act_und=%b act_din=%h exp_und=%b",
                                   i, Underrun, Fir_Din, i >= 5);
            end
        end
        drive(0, 0, 0, '0, 1, 1, DW'($urandom));
        tick();
        for (int i = 0; i < 36; i++) begin
            drive(0, 0, 0, '0, 0, 1, DW'($urandom));
            tick();
        end
        checks++;
        if (Underrun !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL underrun_clear act_und=%b act_busy=%b exp_und=0 exp_busy=0", Underrun, Busy);
        end
    endtask

    task automatic test_hlt_in_flush();
        for (int a = 0; a < NT; a++) begin
            drive(0, 1, a, CWD'($urandom), 0, 1, DW'($urandom));
            tick();
        end
        drive(0, 0, 0, '0, 1, 1, DW'($urandom));
        tick();
        repeat (9) begin
            drive(0, 0, 0, '0, 0, 1, DW'($urandom));
            tick();
        end
        drive(1, 0, 0, '0, 0, 1, DW'($urandom));
        tick();
        drive(0, 0, 0, '0, 0, 1, DW'($urandom));
        checks++;
        if (Busy !== 1'b0 || Samp_Ready !== 1'b1 || Fir_Coeff !== exp_coeff()) begin
            errors++; $display("FAIL hlt_flush act_busy=%b act_rdy=%b coeff_act=%h coeff_exp=%h",
                               Busy, Samp_Ready, Fir_Coeff, exp_coeff());
        end
        drive(0, 0, 0, '0, 1, 1, DW'($urandom));
        tick();
        checks++;
        if (Cmt_Err !== 1'b1 || Busy !== 1'b0) begin
            errors++; $display("FAIL hlt_mask_clear act_err=%b act_busy=%b exp_err=1 exp_busy=0", Cmt_Err, Busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, NT - 1),
                  CWD'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 15) != 0), DW'($urandom));
            tick();
            checks++;
            if ({Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din} !== exp_ctrl() ||
                Fir_Coeff !== exp_coeff()) begin
                errors++; $display("FAIL random i=%0d act=%h exp=%h coeff_act=%h coeff_exp=%h", i,
                    {Busy, Samp_Ready, Cfg_Ready, Out_Valid, Cmt_Err, Underrun, Fir_Din}, exp_ctrl(),
                    Fir_Coeff, exp_coeff());
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, '0, 0, 0, '0);
        test_reset();
        test_commit_full();
        test_incomplete();
        test_same_cycle_commit();
        test_underrun();
        test_hlt_in_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
